riscv_accel_wb_multi: RTL

Parametrised write-back engine that takes a wide accelerator result (AES or similar) and writes it to data memory as a burst of DATA_W-bit words. It holds the core halted while the burst is in flight. It uses a req/gnt memory handshake, so it tolerates stalls from the interconnect. Burst length is selectable per transfer. It sits between the accelerator result register and the core's LSU-side memory port mux.

---
 rtl/riscv_accel_wb_pkg.sv | 17 +
 rtl/riscv_accel_wb_multi.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/riscv_accel_wb_pkg.sv
// Shared types and helpers for the accelerator result write-back engine.
package riscv_accel_wb_pkg;

    typedef enum logic [1:0] {
        WB_IDLE  = 2'd0,
        WB_WRITE = 2'd1,
        WB_DRAIN = 2'd2,
        WB_DONE  = 2'd3
    } wb_state_e;

    // A zero or oversized length means "write the whole result".
    function automatic int unsigned wb_norm_len(input int unsigned len,
                                                input int unsigned num_words);
        return ((len == 0) || (len > num_words)) ? num_words : len;
    endfunction

endpackage

// File: rtl/riscv_accel_wb_multi.sv
// Writes a wide accelerator result to data memory as a req/gnt burst of
// DATA_W-bit words while holding the core halted.
module riscv_accel_wb_multi
    import riscv_accel_wb_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int NUM_WORDS = 4,
    parameter int ADDR_W    = 32,
    localparam int LEN_W    = $clog2(NUM_WORDS + 1)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start_i,
    input  logic [ADDR_W-1:0]           addr_i,
    input  logic [NUM_WORDS*DATA_W-1:0] data_i,
    input  logic [LEN_W-1:0]            len_i,
    output logic                        busy_o,
    output logic                        halt_o,
    output logic                        mem_req_o,
    input  logic                        mem_gnt_i,
    output logic                        mem_we_o,
    output logic [ADDR_W-1:0]           mem_addr_o,
    output logic [DATA_W-1:0]           mem_wdata_o,
    output logic [DATA_W/8-1:0]         mem_be_o,
    output logic                        done_o
);

    localparam int BE_W  = DATA_W / 8;
    localparam int RES_W = NUM_WORDS * DATA_W;
    localparam logic [ADDR_W-1:0] WORD_BYTES = ADDR_W'(BE_W);
    // Clears the byte-offset bits so every word access is naturally aligned.
    localparam logic [ADDR_W-1:0] ADDR_MASK  = ~(ADDR_W'(BE_W - 1));

    wb_state_e         state_q, state_d;
    logic [LEN_W-1:0]  idx_q, idx_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [RES_W-1:0]  data_q, data_d;
    logic              busy_q, busy_d;
    logic              halt_q, halt_d;
    logic              req_q, req_d;
    logic              done_q, done_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        len_d   = len_q;
        data_d  = data_q;
        busy_d  = busy_q;
        halt_d  = halt_q;
        req_d   = req_q;
        done_d  = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;

        case (state_q)
            WB_IDLE: begin
                busy_d = 1'b0;
                halt_d = 1'b0;
                req_d  = 1'b0;
                if (start_i) begin
                    state_d = WB_WRITE;
                    idx_d   = '0;
                    len_d   = LEN_W'(wb_norm_len(32'(len_i), NUM_WORDS));
                    data_d  = data_i;
                    busy_d  = 1'b1;
                    halt_d  = 1'b1;
                    req_d   = 1'b1;
                    addr_d  = addr_i & ADDR_MASK;
                    wdata_d = data_i[DATA_W-1:0];
                end
            end
            WB_WRITE: begin
                // Request, address and data stay frozen until the grant lands.
                if (req_q && mem_gnt_i) begin
                    if (idx_q + LEN_W'(1) == len_q) begin
                        state_d = WB_DRAIN;
                        req_d   = 1'b0;
                    end else begin
                        idx_d   = idx_q + LEN_W'(1);
                        addr_d  = addr_q + WORD_BYTES;
                        wdata_d = data_q[int'(idx_d)*DATA_W +: DATA_W];
                    end
                end
            end
            WB_DRAIN: begin
                state_d = WB_DONE;
                halt_d  = 1'b0;
                done_d  = 1'b1;
            end
            WB_DONE: begin
                state_d = WB_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = WB_IDLE;
                busy_d  = 1'b0;
                halt_d  = 1'b0;
                req_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= WB_IDLE;
            idx_q   <= '0;
            len_q   <= '0;
            data_q  <= '0;
            busy_q  <= 1'b0;
            halt_q  <= 1'b0;
            req_q   <= 1'b0;
            done_q  <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            len_q   <= len_d;
            data_q  <= data_d;
            busy_q  <= busy_d;
            halt_q  <= halt_d;
            req_q   <= req_d;
            done_q  <= done_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    assign busy_o      = busy_q;
    assign halt_o      = halt_q;
    assign mem_req_o   = req_q;
    assign mem_we_o    = req_q;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;
    assign mem_be_o    = {BE_W{req_q}};
    assign done_o      = done_q;

endmodule
